// File: rtl/mem_wb.sv
// -----------------------------------------------------------------------------
// mem_wb -- MEM/WB pipeline register plus the architectural HI, LO and LLbit
// state that is written from the write-back stage.
//
// The wb_* register carries the retiring instruction's GPR write, HI/LO write
// and LLbit write one cycle behind the MEM stage. HI/LO and LLbit are updated
// from the wb_* register contents, so a write becomes architecturally visible
// one edge after it reaches WB.
//
// Ports
//   clk              single clock, all state on rising edge
//   rst              asynchronous active-low reset (0 = reset)
//   stall[5:0]       pipeline stall vector; bit 4 = MEM stalled, bit 5 = WB stalled
//   flush            exception flush
//   mem_wd/wreg/wdata          MEM-stage GPR write address, enable, data
//   mem_whilo/hi/lo            MEM-stage HI/LO write enable and data
//   mem_llbit_we/llbit_value   MEM-stage LLbit write request
//   wb_wd/wreg/wdata           registered GPR write (drives regfile waddr/we/wdata)
//   wb_whilo/hi/lo             registered HI/LO write request
//   wb_llbit_we/llbit_value    registered LLbit write request
//   hi_o, lo_o                 architectural HI and LO (no bypass)
//   llbit_o                    architectural LLbit with write-through bypass
// -----------------------------------------------------------------------------
module mem_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,

    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic              mem_llbit_we,
    input  logic              mem_llbit_value,

    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              wb_llbit_we,
    output logic              wb_llbit_value,

    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              llbit_o
);

    // One retiring instruction's worth of write-back side effects.
    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic              whilo;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              llbit_we;
        logic              llbit_value;
    } wb_pkt_t;

    // What the pipeline register does at the next edge.
    typedef enum logic [1:0] {
        ACT_CAPTURE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_HOLD    = 2'd2
    } wb_act_t;

    wb_pkt_t           mem_pkt;
    wb_pkt_t           wb_q;
    wb_pkt_t           wb_d;
    wb_act_t           act;

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              llbit_q;

    // Only the MEM and WB stall bits matter here; the upstream bits are
    // folded into a sink so the port keeps the full pipeline-wide vector.
    logic              unused_stall;
    assign unused_stall = ^stall[3:0];

    assign mem_pkt = '{
        wd:          mem_wd,
        wreg:        mem_wreg,
        wdata:       mem_wdata,
        whilo:       mem_whilo,
        hi:          mem_hi,
        lo:          mem_lo,
        llbit_we:    mem_llbit_we,
        llbit_value: mem_llbit_value
    };

    // ------------------------------------------------------------------
    // Pipeline-register action. Flush wins, then a MEM stall with WB free
    // inserts a bubble, a stall of both holds, and a free MEM captures.
    // MEM free with WB stalled cannot happen in a correct pipeline; it
    // simply falls through to capture.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        act  = ACT_CAPTURE;
        wb_d = mem_pkt;

        if (flush) begin
            act = ACT_BUBBLE;
        end else if (stall[4] && !stall[5]) begin
            act = ACT_BUBBLE;
        end else if (stall[4] && stall[5]) begin
            act = ACT_HOLD;
        end

        case (act)
            ACT_BUBBLE: wb_d = '0;
            ACT_HOLD:   wb_d = wb_q;
            default:    wb_d = mem_pkt;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    // ------------------------------------------------------------------
    // HI/LO commit from the WB-stage request. This is independent of flush:
    // the instruction sitting in WB has already retired, so its write lands
    // even while the pipeline register behind it is being bubbled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_q.whilo) begin
            hi_q <= wb_q.hi;
            lo_q <= wb_q.lo;
        end
    end

    // ------------------------------------------------------------------
    // LLbit: an exception breaks any LL/SC pair, so flush clears it ahead
    // of a pending write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llbit_q <= 1'b0;
        end else if (flush) begin
            llbit_q <= 1'b0;
        end else if (wb_q.llbit_we) begin
            llbit_q <= wb_q.llbit_value;
        end
    end

    // Write-through view of LLbit so an SC in MEM sees an LL/flush that is
    // committing this very cycle.
    always_comb begin
        llbit_o = llbit_q;
        if (flush) begin
            llbit_o = 1'b0;
        end else if (wb_q.llbit_we) begin
            llbit_o = wb_q.llbit_value;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Register 0 writes pass through untouched; the register file
    // is the one that discards them.
    // ------------------------------------------------------------------
    assign wb_wd          = wb_q.wd;
    assign wb_wreg        = wb_q.wreg;
    assign wb_wdata       = wb_q.wdata;
    assign wb_whilo       = wb_q.whilo;
    assign wb_hi          = wb_q.hi;
    assign wb_lo          = wb_q.lo;
    assign wb_llbit_we    = wb_q.llbit_we;
    assign wb_llbit_value = wb_q.llbit_value;

    assign hi_o           = hi_q;
    assign lo_o           = lo_q;

endmodule

// File: tb/tb_mem_wb.sv
// -----------------------------------------------------------------------------
// tb_mem_wb -- self-checking bench for mem_wb.
//
// Inputs change on the falling edge; combinational outputs are checked just
// before the rising edge and registered outputs just after it. A behavioural
// model of the write-back stage (a record of pending side effects plus the
// architectural HI/LO/LLbit values) supplies every expected value.
// -----------------------------------------------------------------------------
module tb_mem_wb;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic [AW-1:0] mem_wd;
    logic          mem_wreg;
    logic [DW-1:0] mem_wdata;
    logic          mem_whilo;
    logic [DW-1:0] mem_hi;
    logic [DW-1:0] mem_lo;
    logic          mem_llbit_we;
    logic          mem_llbit_value;

    logic [AW-1:0] wb_wd;
    logic          wb_wreg;
    logic [DW-1:0] wb_wdata;
    logic          wb_whilo;
    logic [DW-1:0] wb_hi;
    logic [DW-1:0] wb_lo;
    logic          wb_llbit_we;
    logic          wb_llbit_value;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;
    logic          llbit_o;

    always #5 clk = ~clk;

    mem_wb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .mem_wd          (mem_wd),
        .mem_wreg        (mem_wreg),
        .mem_wdata       (mem_wdata),
        .mem_whilo       (mem_whilo),
        .mem_hi          (mem_hi),
        .mem_lo          (mem_lo),
        .mem_llbit_we    (mem_llbit_we),
        .mem_llbit_value (mem_llbit_value),
        .wb_wd           (wb_wd),
        .wb_wreg         (wb_wreg),
        .wb_wdata        (wb_wdata),
        .wb_whilo        (wb_whilo),
        .wb_hi           (wb_hi),
        .wb_lo           (wb_lo),
        .wb_llbit_we     (wb_llbit_we),
        .wb_llbit_value  (wb_llbit_value),
        .hi_o            (hi_o),
        .lo_o            (lo_o),
        .llbit_o         (llbit_o)
    );

    // ---------------------------------------------------------------- model
    typedef struct {
        logic [AW-1:0] wd;
        logic          wreg;
        logic [DW-1:0] wdata;
        logic          whilo;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic          llwe;
        logic          llval;
    } rec_t;

    rec_t          m_wb;      // instruction currently in WB
    logic [DW-1:0] m_hi;      // architectural HI
    logic [DW-1:0] m_lo;      // architectural LO
    logic          m_ll;      // architectural LLbit

    int n_checks = 0;
    int n_fail   = 0;
    int n_illegal = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic rec_t empty_rec();
        rec_t r;
        r = '{wd: '0, wreg: 1'b0, wdata: '0, whilo: 1'b0, hi: '0, lo: '0, llwe: 1'b0, llval: 1'b0};
        return r;
    endfunction

    function automatic rec_t mem_rec();
        rec_t r;
        r = '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata, whilo: mem_whilo,
              hi: mem_hi, lo: mem_lo, llwe: mem_llbit_we, llval: mem_llbit_value};
        return r;
    endfunction

    // LLbit as an SC in MEM would see it right now.
    function automatic logic exp_llbit();
        if (flush) return 1'b0;
        if (m_wb.llwe) return m_wb.llval;
        return m_ll;
    endfunction

    task automatic model_reset();
        m_wb = empty_rec();
        m_hi = '0;
        m_lo = '0;
        m_ll = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".wb_wd"},          64'(wb_wd),          64'(m_wb.wd));
        check({tag, ".wb_wreg"},        64'(wb_wreg),        64'(m_wb.wreg));
        check({tag, ".wb_wdata"},       64'(wb_wdata),       64'(m_wb.wdata));
        check({tag, ".wb_whilo"},       64'(wb_whilo),       64'(m_wb.whilo));
        check({tag, ".wb_hi"},          64'(wb_hi),          64'(m_wb.hi));
        check({tag, ".wb_lo"},          64'(wb_lo),          64'(m_wb.lo));
        check({tag, ".wb_llbit_we"},    64'(wb_llbit_we),    64'(m_wb.llwe));
        check({tag, ".wb_llbit_value"}, 64'(wb_llbit_value), 64'(m_wb.llval));
        check({tag, ".hi_o"},           64'(hi_o),           64'(m_hi));
        check({tag, ".lo_o"},           64'(lo_o),           64'(m_lo));
        check({tag, ".llbit_o"},        64'(llbit_o),        64'(exp_llbit()));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wb_wd"},          64'(wb_wd),          64'd0);
        check({tag, ".wb_wreg"},        64'(wb_wreg),        64'd0);
        check({tag, ".wb_wdata"},       64'(wb_wdata),       64'd0);
        check({tag, ".wb_whilo"},       64'(wb_whilo),       64'd0);
        check({tag, ".wb_hi"},          64'(wb_hi),          64'd0);
        check({tag, ".wb_lo"},          64'(wb_lo),          64'd0);
        check({tag, ".wb_llbit_we"},    64'(wb_llbit_we),    64'd0);
        check({tag, ".wb_llbit_value"}, 64'(wb_llbit_value), 64'd0);
        check({tag, ".hi_o"},           64'(hi_o),           64'd0);
        check({tag, ".lo_o"},           64'(lo_o),           64'd0);
        check({tag, ".llbit_o"},        64'(llbit_o),        64'd0);
    endtask

    // One clock: called on a falling edge with inputs already driven,
    // returns on the next falling edge.
    task automatic step(input string tag);
        rec_t          nxt;
        logic [DW-1:0] nhi;
        logic [DW-1:0] nlo;
        logic          nll;
        #1;
        if (!stall[4] && stall[5]) begin
            n_illegal++;
            $display("warning %s: illegal stall=%b (MEM advancing into a stalled WB)", tag, stall);
        end
        check({tag, ".pre.llbit_o"}, 64'(llbit_o), 64'(exp_llbit()));

        // The instruction already in WB retires at this edge.
        nhi = m_wb.whilo ? m_wb.hi : m_hi;
        nlo = m_wb.whilo ? m_wb.lo : m_lo;
        if (flush)          nll = 1'b0;
        else if (m_wb.llwe) nll = m_wb.llval;
        else                nll = m_ll;

        // What moves into WB.
        if (flush)                       nxt = empty_rec();
        else if (stall[4] && !stall[5])  nxt = empty_rec();
        else if (stall[4] && stall[5])   nxt = m_wb;
        else                             nxt = mem_rec();

        @(posedge clk);
        m_wb = nxt;
        m_hi = nhi;
        m_lo = nlo;
        m_ll = nll;
        #1;
        check_regs({tag, ".post"});
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall           = '0;
        flush           = 1'b0;
        mem_wd          = '0;
        mem_wreg        = 1'b0;
        mem_wdata       = '0;
        mem_whilo       = 1'b0;
        mem_hi          = '0;
        mem_lo          = '0;
        mem_llbit_we    = 1'b0;
        mem_llbit_value = 1'b0;
    endtask

    task automatic random_inputs();
        int   r;
        logic [3:0] low;
        r   = $urandom_range(0, 19);
        low = 4'($urandom());
        if (r < 11)       stall = {2'b00, low};
        else if (r < 14)  stall = {2'b01, low};
        else if (r < 17)  stall = {2'b11, low};
        else if (r < 19)  stall = 6'b111111;
        else              stall = {2'b10, low};
        flush           = ($urandom_range(0, 9) == 0);
        mem_wd          = AW'($urandom());
        mem_wreg        = 1'($urandom());
        mem_wdata       = $urandom();
        mem_whilo       = 1'($urandom());
        mem_hi          = $urandom();
        mem_lo          = $urandom();
        mem_llbit_we    = 1'($urandom());
        mem_llbit_value = 1'($urandom());
    endtask

    // ---------------------------------------------------------------- test
    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();

        // Reset must act without any clock edge (first rising edge is t=5).
        #2;
        check_all_zero("reset0");

        @(negedge clk);
        rst = 1'b1;

        // Advance: one-cycle MEM->WB latency.
        mem_wd = 5; mem_wreg = 1'b1; mem_wdata = 32'hDEADBEEF;
        step("advance");
        check("advance.wb_wd",    64'(wb_wd),    64'd5);
        check("advance.wb_wreg",  64'(wb_wreg),  64'd1);
        check("advance.wb_wdata", 64'(wb_wdata), 64'hDEADBEEF);

        // Stall: MEM stalled with WB free bubbles, then both stalled holds.
        stall = 6'b011111;
        step("stall_bubble");
        check("stall_bubble.wb_wreg",  64'(wb_wreg),  64'd0);
        check("stall_bubble.wb_wdata", 64'(wb_wdata), 64'd0);
        stall = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            step("stall_hold");
            check("stall_hold.wb_wd",    64'(wb_wd),    64'd0);
            check("stall_hold.wb_wdata", 64'(wb_wdata), 64'd0);
        end

        // Register 0 write passes unmasked.
        idle_inputs();
        mem_wd = 0; mem_wreg = 1'b1; mem_wdata = 32'hA5A5A5A5;
        step("r0");
        check("r0.wb_wreg",  64'(wb_wreg),  64'd1);
        check("r0.wb_wdata", 64'(wb_wdata), 64'hA5A5A5A5);

        // HI/LO: captured into WB, architectural after the following edge.
        idle_inputs();
        mem_whilo = 1'b1; mem_hi = 32'h12345678; mem_lo = 32'h9ABCDEF0;
        step("hilo_cap");
        check("hilo_cap.hi_o", 64'(hi_o), 64'd0);
        idle_inputs();
        step("hilo_commit");
        check("hilo_commit.hi_o", 64'(hi_o), 64'h12345678);
        check("hilo_commit.lo_o", 64'(lo_o), 64'h9ABCDEF0);
        mem_hi = 32'hFFFFFFFF; mem_lo = 32'hFFFFFFFF;
        step("hilo_hold");
        check("hilo_hold.hi_o", 64'(hi_o), 64'h12345678);

        // LLbit write-through bypass.
        idle_inputs();
        mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
        step("ll_cap");
        idle_inputs();
        #1;
        check("ll_bypass.llbit_o", 64'(llbit_o), 64'd1);
        step("ll_commit");
        check("ll_commit.llbit_o", 64'(llbit_o), 64'd1);

        // Flush with a GPR + HI/LO write pending in WB.
        idle_inputs();
        mem_wreg = 1'b1; mem_wd = 7; mem_wdata = 32'h0BADF00D;
        mem_whilo = 1'b1; mem_hi = 32'hCAFEBABE; mem_lo = 32'h00C0FFEE;
        step("pre_flush");
        flush = 1'b1;
        mem_wreg = 1'b1; mem_wd = 9;
        #1;
        check("flush.pending_wreg", 64'(wb_wreg), 64'd1);
        check("flush.llbit_o",      64'(llbit_o), 64'd0);
        step("flush");
        check("flush.wb_wreg", 64'(wb_wreg), 64'd0);
        check("flush.hi_o",    64'(hi_o),    64'hCAFEBABE);
        idle_inputs();
        #1;
        check("flush.llbit_reg", 64'(llbit_o), 64'd0);

        // Async reset between edges with state pending.
        idle_inputs();
        mem_whilo = 1'b1; mem_hi = 32'h12345678; mem_lo = 32'h1;
        step("ar_load");
        idle_inputs();
        mem_wreg = 1'b1; mem_wd = 3; mem_wdata = 32'h55;
        step("ar_pend");
        check("ar_pend.hi_o", 64'(hi_o), 64'h12345678);
        stall = 6'b111111; flush = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        check_all_zero("async_rst");
        #1;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        mem_wd = 4; mem_wreg = 1'b1; mem_wdata = 32'h77;
        step("after_rst");

        // Randomized traffic, with occasional mid-cycle resets.
        for (int n = 0; n < 3000; n++) begin
            random_inputs();
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                #1;
                model_reset();
                check_all_zero("rand_rst");
                rst = 1'b1;
            end
            step("rand");
        end

        $display("stall-vector warnings flagged: %0d", n_illegal);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
